// File: rtl/maindec_mc.sv
// -----------------------------------------------------------------------------
// maindec_mc -- multicycle LEGv8 main decoder / control FSM
//
// Each instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB. Invalid
// opcodes divert through EXC, which raises a synchronous exception. Optional
// external interrupts are sampled only in FETCH.
//
// Optional feature macro: MAINDEC_IRQ_EN
//   defined   : in FETCH, with in_exc=0, any set irq bit diverts to EXC with
//               esr_code = {1'b1, index of lowest set irq bit}
//   undefined : irq is ignored; in_exc is set only by invalid opcodes
//
// Parameters:
//   OP_W  : opcode input width; the top 11 bits are decoded (OP_W >= 11)
//   N_IRQ : number of level-sensitive IRQ lines (bit 0 highest priority)
//   ESR_W : exception cause width; N_IRQ must not exceed 2**(ESR_W-1)
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   Op                   opcode from the instruction register (DECODE onward)
//   irq                  external interrupt requests
//   Reg2Loc..Branch      datapath controls
//   ALUSrc               00 reg, 01 imm, 10 system register
//   ALUOp                ALU control class
//   ERet                 PC <- ELR (EXEC of ERET)
//   NotAnInstr           invalid opcode seen in DECODE
//   PCWrite, IRWrite     PC / IR load enables
//   ExcWrite, PCSrcExc   latch ELR/ESR, PC <- exception vector
//   esr_code             registered exception cause
//   in_exc               exception mask (PSTATE.I)
//   state_o              current FSM state
//
// Static fields (Reg2Loc, ALUSrc, ALUOp, MemtoReg) are driven from DECODE
// until the return to FETCH. In DECODE they come straight from Op; from EXEC
// on they come from the class latched at the end of DECODE, so later changes
// on Op have no effect.
//
// Exception/mask register updates land on the transition into the state that
// performs the action: esr_code and in_exc are already updated while EXC is
// active, and an ERET has cleared in_exc by the time EXEC is active.
// -----------------------------------------------------------------------------
module maindec_mc #(
   parameter int OP_W  = 11,
   parameter int N_IRQ = 4,
   parameter int ESR_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OP_W-1:0]  Op,
   input  logic [N_IRQ-1:0] irq,
   output logic             Reg2Loc,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Branch,
   output logic [1:0]       ALUSrc,
   output logic [1:0]       ALUOp,
   output logic             ERet,
   output logic             NotAnInstr,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             ExcWrite,
   output logic             PCSrcExc,
   output logic [ESR_W-1:0] esr_code,
   output logic             in_exc,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_EXC    = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_INV, C_R, C_LDUR, C_STUR, C_CBZ, C_ERET, C_MRS
   } cls_t;

   state_t state, next_state;
   cls_t   op_cls, cls_q, cls;

   logic [10:0]      opc;
   logic             irq_take;
   logic [ESR_W-2:0] irq_idx;

   assign opc     = Op[OP_W-1 -: 11];
   assign state_o = state;

   // Opcode classification
   always_comb begin
      op_cls = C_INV;
      casez (opc)
         11'b111_1100_0010: op_cls = C_LDUR;
         11'b111_1100_0000: op_cls = C_STUR;
         11'b101_1010_0???: op_cls = C_CBZ;
         11'b100_0101_1000,
         11'b110_0101_1000,
         11'b100_0101_0000,
         11'b101_0101_0000: op_cls = C_R;
         11'b110_1011_0100: op_cls = C_ERET;
         11'b110_1010_1001: op_cls = C_MRS;
         default:           op_cls = C_INV;
      endcase
   end

   // In DECODE the class is not latched yet, so use the live decode
   assign cls = (state == S_DECODE) ? op_cls : cls_q;

`ifdef MAINDEC_IRQ_EN
   // Lowest set bit wins: scan from the top so the last hit is the lowest
   always_comb begin
      irq_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (irq[i]) irq_idx = (ESR_W-1)'(i);
      end
   end
   assign irq_take = (state == S_FETCH) && !in_exc && (|irq);
`else
   logic unused_irq;
   assign unused_irq = ^irq;
   assign irq_idx    = '0;
   assign irq_take   = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = irq_take ? S_EXC : S_DECODE;
         S_DECODE: next_state = (op_cls == C_INV) ? S_EXC : S_EXEC;
         S_EXEC: begin
            case (cls_q)
               C_LDUR, C_STUR: next_state = S_MEM;
               C_R, C_MRS:     next_state = S_WB;
               default:        next_state = S_FETCH;
            endcase
         end
         S_MEM:    next_state = (cls_q == C_LDUR) ? S_WB : S_FETCH;
         S_WB:     next_state = S_FETCH;
         S_EXC:    next_state = S_FETCH;
         default:  next_state = S_FETCH;
      endcase
   end

   // Class latch, exception cause and mask
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cls_q    <= C_INV;
         esr_code <= '0;
         in_exc   <= 1'b0;
      end else begin
         if (state == S_DECODE) cls_q <= op_cls;
         if (irq_take) begin
            esr_code <= {1'b1, irq_idx};
            in_exc   <= 1'b1;
         end else if (state == S_DECODE) begin
            if (op_cls == C_INV) begin
               esr_code <= ESR_W'(1);
               in_exc   <= 1'b1;
            end else if (op_cls == C_ERET) begin
               in_exc   <= 1'b0;
            end
         end
      end
   end

   // Output logic
   always_comb begin
      Reg2Loc    = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Branch     = 1'b0;
      ALUSrc     = 2'b00;
      ALUOp      = 2'b00;
      ERet       = 1'b0;
      NotAnInstr = 1'b0;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      ExcWrite   = 1'b0;
      PCSrcExc   = 1'b0;

      // Static fields while an instruction is in flight
      if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
         case (cls)
            C_R:    ALUOp = 2'b10;
            C_LDUR: begin ALUSrc = 2'b01; MemtoReg = 1'b1; end
            C_STUR: begin Reg2Loc = 1'b1; ALUSrc = 2'b01; end
            C_CBZ:  begin Reg2Loc = 1'b1; ALUOp = 2'b01; end
            C_MRS:  ALUSrc = 2'b10;
            default: ;
         endcase
      end

      case (state)
         S_FETCH: begin
            if (!irq_take) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
            end
         end
         S_DECODE: NotAnInstr = (op_cls == C_INV);
         S_EXEC: begin
            if (cls_q == C_CBZ) Branch = 1'b1;
            if (cls_q == C_ERET) begin
               ERet    = 1'b1;
               PCWrite = 1'b1;
            end
         end
         S_MEM: begin
            if (cls_q == C_LDUR) MemRead  = 1'b1;
            if (cls_q == C_STUR) MemWrite = 1'b1;
         end
         S_WB:  RegWrite = 1'b1;
         S_EXC: begin
            ExcWrite = 1'b1;
            PCSrcExc = 1'b1;
            PCWrite  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_maindec_mc.sv
// -----------------------------------------------------------------------------
// tb_maindec_mc -- self-checking bench for maindec_mc
//
// A behavioural model expands each instruction into its expected per-cycle
// output records (from the instruction's class rules) and pushes them on an
// expected queue; every cycle the DUT outputs are compared with the head.
// A directed table adds latency / esr_code / in_exc expectations per
// instruction, followed by a reset-in-EXEC sequence and randomized traffic.
// -----------------------------------------------------------------------------
module tb_maindec_mc;

   localparam int OP_W  = 11;
   localparam int N_IRQ = 4;
   localparam int ESR_W = 4;

   logic             clk;
   logic             reset;
   logic [OP_W-1:0]  Op;
   logic [N_IRQ-1:0] irq;
   logic             Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
   logic [1:0]       ALUSrc, ALUOp;
   logic             ERet, NotAnInstr, PCWrite, IRWrite, ExcWrite, PCSrcExc;
   logic [ESR_W-1:0] esr_code;
   logic             in_exc;
   logic [2:0]       state_o;

   maindec_mc #(.OP_W(OP_W), .N_IRQ(N_IRQ), .ESR_W(ESR_W)) dut (
      .clk(clk), .reset(reset), .Op(Op), .irq(irq),
      .Reg2Loc(Reg2Loc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
      .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ERet(ERet), .NotAnInstr(NotAnInstr),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .ExcWrite(ExcWrite),
      .PCSrcExc(PCSrcExc), .esr_code(esr_code), .in_exc(in_exc),
      .state_o(state_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- observed output record ----------------
   typedef struct packed {
      logic [2:0]       st;
      logic             irw, pcw, r2l;
      logic [1:0]       alusrc, aluop;
      logic             m2r, rw, mr, mw, br, eret, nai, excw, pcse;
      logic [ESR_W-1:0] esr;
      logic             inexc;
   } obs_t;
   localparam int OW = $bits(obs_t);

   typedef enum {K_INV, K_R, K_LDUR, K_STUR, K_CBZ, K_ERET, K_MRS} kind_t;

   localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
   localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
   localparam logic [10:0] OP_CBZ  = 11'b101_1010_0000;
   localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
   localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
   localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
   localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
   localparam logic [10:0] OP_ERET = 11'b110_1011_0100;
   localparam logic [10:0] OP_MRS  = 11'b110_1010_1001;

   // ---------------- scoreboard ----------------
   logic [OW-1:0]    exp_q[$];
   logic [OP_W-1:0]  op_q[$];
   int               n_checks, n_pass;
   logic             m_in_exc;
   logic [ESR_W-1:0] m_esr;

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic obs_t get_obs();
      obs_t o;
      o.st = state_o; o.irw = IRWrite; o.pcw = PCWrite; o.r2l = Reg2Loc;
      o.alusrc = ALUSrc; o.aluop = ALUOp; o.m2r = MemtoReg; o.rw = RegWrite;
      o.mr = MemRead; o.mw = MemWrite; o.br = Branch; o.eret = ERet;
      o.nai = NotAnInstr; o.excw = ExcWrite; o.pcse = PCSrcExc;
      o.esr = esr_code; o.inexc = in_exc;
      return o;
   endfunction

   // ---------------- behavioural model ----------------
   function automatic kind_t classify(input logic [10:0] op);
      logic [10:0] cbz_mask;
      cbz_mask = 11'b111_1111_1000;
      if (op == OP_LDUR) return K_LDUR;
      if (op == OP_STUR) return K_STUR;
      if ((op & cbz_mask) == OP_CBZ) return K_CBZ;
      if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return K_R;
      if (op == OP_ERET) return K_ERET;
      if (op == OP_MRS) return K_MRS;
      return K_INV;
   endfunction

   function automatic obs_t blank(input int st);
      obs_t o;
      o = '0;
      o.st = st[2:0];
      o.esr = m_esr;
      o.inexc = m_in_exc;
      return o;
   endfunction

   function automatic obs_t with_statics(input obs_t o_in, input kind_t k);
      obs_t o;
      o = o_in;
      case (k)
         K_R:    o.aluop = 2'b10;
         K_LDUR: begin o.alusrc = 2'b01; o.m2r = 1'b1; end
         K_STUR: begin o.r2l = 1'b1; o.alusrc = 2'b01; end
         K_CBZ:  begin o.r2l = 1'b1; o.aluop = 2'b01; end
         K_MRS:  o.alusrc = 2'b10;
         default: ;
      endcase
      return o;
   endfunction

   task automatic push(input obs_t o, input logic [OP_W-1:0] opv);
      exp_q.push_back(o);
      op_q.push_back(opv);
   endtask

   task automatic model_instr(input logic [OP_W-1:0] op, input logic [N_IRQ-1:0] irqv);
      obs_t o;
      kind_t k;
      logic take;
      logic [OP_W-1:0] g;
      int idx;
      k = classify(op[OP_W-1 -: 11]);
      g = OP_W'($urandom);
      take = 1'b0;
`ifdef MAINDEC_IRQ_EN
      take = !m_in_exc && (irqv != '0);
`endif
      o = blank(0);
      if (!take) begin o.irw = 1'b1; o.pcw = 1'b1; end
      push(o, g);
      if (take) begin
         idx = 0;
         for (int i = N_IRQ - 1; i >= 0; i--) if (irqv[i]) idx = i;
         m_esr = {1'b1, idx[ESR_W-2:0]};
         m_in_exc = 1'b1;
         o = blank(5); o.excw = 1'b1; o.pcse = 1'b1; o.pcw = 1'b1;
         push(o, g);
         return;
      end
      o = with_statics(blank(1), k);
      if (k == K_INV) o.nai = 1'b1;
      push(o, op);
      if (k == K_INV) begin
         m_esr = ESR_W'(1);
         m_in_exc = 1'b1;
         o = blank(5); o.excw = 1'b1; o.pcse = 1'b1; o.pcw = 1'b1;
         push(o, g);
         return;
      end
      if (k == K_ERET) m_in_exc = 1'b0;
      o = with_statics(blank(2), k);
      if (k == K_CBZ) o.br = 1'b1;
      if (k == K_ERET) begin o.eret = 1'b1; o.pcw = 1'b1; end
      push(o, op);
      if (k == K_LDUR) begin
         o = with_statics(blank(3), k); o.mr = 1'b1; push(o, op);
         o = with_statics(blank(4), k); o.rw = 1'b1; push(o, op);
      end else if (k == K_STUR) begin
         o = with_statics(blank(3), k); o.mw = 1'b1; push(o, op);
      end else if (k == K_R || k == K_MRS) begin
         o = with_statics(blank(4), k); o.rw = 1'b1; push(o, op);
      end
   endtask

   // ---------------- driver ----------------
   // Entered just after a rising edge with the DUT in FETCH; returns the same way.
   task automatic run_instr(input logic [OP_W-1:0] op, input logic [N_IRQ-1:0] irqv,
                            output int lat);
      logic [OW-1:0] e;
      model_instr(op, irqv);
      irq = irqv;
      lat = 0;
      for (int c = 0; c < 12; c++) begin
         if (op_q.size() > 0) Op = op_q.pop_front();
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", get_obs(), e);
         end
         @(posedge clk); #1;
         lat++;
         if (state_o == 3'd0) break;
      end
      check_int("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      op_q.delete();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [OP_W-1:0]  op;
      logic [N_IRQ-1:0] irq;
      int               lat;
      logic [ESR_W-1:0] esr;
      logic             inexc;
   } vec_t;

   vec_t        vecs[13];
   logic [10:0] vops[8];
   obs_t        rst_exp;
   int          lat;
   logic [OP_W-1:0]  rop;
   logic [N_IRQ-1:0] rirq;
   int          r;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_pass = 0;
      m_in_exc = 1'b0; m_esr = '0;

      vecs[0]  = '{OP_ADD,         4'b0000, 4, 4'd0, 1'b0};
      vecs[1]  = '{OP_LDUR,        4'b0000, 5, 4'd0, 1'b0};
      vecs[2]  = '{OP_STUR,        4'b0000, 4, 4'd0, 1'b0};
      vecs[3]  = '{11'b101_1010_0101, 4'b0000, 3, 4'd0, 1'b0};
      vecs[4]  = '{OP_MRS,         4'b0000, 4, 4'd0, 1'b0};
      vecs[5]  = '{OP_ERET,        4'b0000, 3, 4'd0, 1'b0};
`ifdef MAINDEC_IRQ_EN
      vecs[6]  = '{OP_ADD,         4'b1111, 2, 4'b1000, 1'b1};
`else
      vecs[6]  = '{OP_ADD,         4'b1111, 4, 4'd0, 1'b0};
`endif
      vecs[7]  = '{11'b000_0000_0000, 4'b0000, 3, 4'd1, 1'b1};
      vecs[8]  = '{11'b111_1111_1111, 4'b0000, 3, 4'd1, 1'b1};
      vecs[9]  = '{OP_SUB,         4'b0110, 4, 4'd1, 1'b1};
      vecs[10] = '{OP_ERET,        4'b0000, 3, 4'd1, 1'b0};
`ifdef MAINDEC_IRQ_EN
      vecs[11] = '{OP_ORR,         4'b0110, 2, 4'b1001, 1'b1};
      vecs[12] = '{OP_ERET,        4'b0000, 3, 4'b1001, 1'b0};
`else
      vecs[11] = '{OP_ORR,         4'b0110, 4, 4'd1, 1'b0};
      vecs[12] = '{OP_ERET,        4'b0000, 3, 4'd1, 1'b0};
`endif
      vops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_ERET, OP_MRS};

      // ---- reset ----
      reset = 1'b0; Op = '0; irq = '0;
      #12;
      rst_exp = '0; rst_exp.irw = 1'b1; rst_exp.pcw = 1'b1;
      check("reset_state", get_obs(), rst_exp);
      @(posedge clk); #1;
      reset = 1'b1;

      // ---- directed table ----
      for (int i = 0; i < 13; i++) begin
         run_instr(vecs[i].op, vecs[i].irq, lat);
         check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check_int($sformatf("vec%0d_esr", i), int'(esr_code), int'(vecs[i].esr));
         check_int($sformatf("vec%0d_in_exc", i), int'(in_exc), int'(vecs[i].inexc));
      end
      irq = '0;

      // ---- reset asserted mid-EXEC ----
      Op = OP_ADD;
      @(posedge clk); #1;                 // DECODE
      @(posedge clk); #1;                 // EXEC
      check_int("pre_reset_exec", int'(state_o), 2);
      reset = 1'b0;
      #1;
      check_int("rst_mid_state", int'(state_o), 0);
      check_int("rst_mid_irwrite", int'(IRWrite), 1);
      check_int("rst_mid_regwrite", int'(RegWrite), 0);
      #2;
      reset = 1'b1;
      #2;
      check_int("rst_rel_state", int'(state_o), 0);
      check_int("rst_rel_regwrite", int'(RegWrite), 0);
      @(posedge clk); #1;
      check_int("rst_next_state", int'(state_o), 1);
      check_int("rst_next_regwrite", int'(RegWrite), 0);
      for (int c = 0; c < 8 && state_o != 3'd0; c++) begin
         @(posedge clk); #1;
      end
      check_int("rst_resync", int'(state_o), 0);
      m_in_exc = 1'b0; m_esr = '0;

      // ---- randomized traffic ----
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) rop = vops[$urandom_range(0, 7)];
         else if (r == 6) rop = OP_CBZ | 11'($urandom_range(0, 7));
         else rop = OP_W'($urandom);
`ifdef MAINDEC_IRQ_EN
         rirq = ($urandom_range(0, 3) == 0) ? N_IRQ'($urandom) : '0;
`else
         rirq = N_IRQ'($urandom);
`endif
         run_instr(rop, rirq, lat);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/maindec_mc.md
Name: maindec_mc

Overview:
- Multicycle successor to the single-cycle LEGv8 main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a Moore/Mealy FSM.
- Raises synchronous exceptions for invalid opcodes and, optionally, takes prioritised external IRQs.
- Sits between the instruction register and datapath; drives datapath controls plus PC/IR/exception-register enables.

Parameters:
OP_W, 11, opcode field width (bits [OP_W-1 -: 11] compared; must be ≥11)
N_IRQ, 4, number of level-sensitive IRQ lines
ESR_W, 4, exception cause width; requires N_IRQ ≤ 2^(ESR_W-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
Op  in  OP_W  opcode from instruction register (valid from DECODE onward)
irq  in  N_IRQ  external interrupt requests, level, bit 0 highest priority
Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1  datapath controls
ALUSrc  out  2  00 reg, 01 imm, 10 system register
ALUOp  out  2  ALU control class
ERet  out  1  PC <- ELR, in EXEC of ERET
NotAnInstr  out  1  invalid opcode detected (DECODE)
PCWrite, IRWrite  out  1  PC / IR load enables
ExcWrite  out  1  latch ELR and ESR
PCSrcExc  out  1  PC <- exception vector
esr_code  out  ESR_W  cause for ESR
in_exc  out  1  exception mask (PSTATE.I)
state_o  out  3  current FSM state (debug)

Behaviour:
- Reset (async, active-low): state=FETCH, in_exc=0, all outputs 0 except IRWrite=1, PCWrite=1 (FETCH decode), state_o=0.
- Decode classes:
  - LDUR 111_1100_0010
  - STUR 111_1100_0000
  - CBZ 101_1010_0xxx
  - R-format: ADD 100_0101_1000, SUB 110_0101_1000, AND 100_0101_0000, ORR 101_0101_0000
  - ERET 110_1011_0100
  - MRS 110_1010_1001
  - everything else invalid.
- Static fields, held from DECODE until FETCH:
  - R: Reg2Loc 0, ALUSrc 00, ALUOp 10
  - LDUR: ALUSrc 01, ALUOp 00, MemtoReg 1
  - STUR: Reg2Loc 1, ALUSrc 01, ALUOp 00
  - CBZ: Reg2Loc 1, ALUSrc 00, ALUOp 01
  - MRS: ALUSrc 10, ALUOp 00
  - ERET/invalid: all 0.
- States (state_o encoding): FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, EXC 5.
  - FETCH: IRWrite=1, PCWrite=1 → DECODE. If an IRQ is pending (see optional feature), outputs are suppressed and the FSM goes → EXC.
  - DECODE: if invalid → NotAnInstr=1 for this cycle, esr_code=1 latched → EXC; else → EXEC.
  - EXEC: CBZ asserts Branch=1 → FETCH. ERET asserts ERet=1, PCWrite=1, clears in_exc → FETCH. LDUR/STUR → MEM. R/MRS → WB.
  - MEM: LDUR asserts MemRead=1 → WB. STUR asserts MemWrite=1 → FETCH.
  - WB: RegWrite=1 → FETCH.
  - EXC: ExcWrite=1, PCSrcExc=1, PCWrite=1, sets in_exc=1 → FETCH.
- Latency in cycles: R 4, MRS 4, LDUR 5, STUR 4, CBZ 3, ERET 3, invalid 3, IRQ entry 2 (FETCH, EXC).
- esr_code:
  - Registered; reset 0.
  - 1 for invalid opcode.
  - {1'b1, idx} for IRQ, where idx is the lowest set unmasked bit.
  - Held until the next exception.
- Invalid opcode while in_exc=1 is still taken; ELR/ESR are overwritten.
- ERET while in_exc=0 is executed normally; in_exc stays 0.
- Reset asserted mid-instruction returns to FETCH immediately; no partial RegWrite/MemWrite after deassertion.
- Op changes outside DECODE..WB are ignored.

Optional Feature:
- Macro MAINDEC_IRQ_EN.
- Defined:
  - In FETCH, if in_exc=0 and any irq bit is set, take EXC with esr_code={1,idx}.
  - IRQ is sampled only in FETCH, so instructions are never interrupted mid-sequence.
  - An IRQ outranks fetch.
- Undefined: the irq port exists but is ignored, and in_exc is set only by invalid opcodes.

Test Plan:
- Reset low mid-EXEC, release → next cycle state_o=0, IRWrite=1, no RegWrite pulse seen.
- Op=111_1100_0010 → states 0,1,2,3,4. MemRead=1 only in state 3; RegWrite=1 with MemtoReg=1 only in state 4. Back to FETCH after 5 cycles.
- Op=101_1010_0101 → Branch=1 in EXEC, ALUOp=01, Reg2Loc=1. FETCH on the 4th cycle.
- Op=000_0000_0000 → NotAnInstr=1 in DECODE; ExcWrite=PCSrcExc=1 next cycle; esr_code=1, in_exc=1. Then Op=110_1011_0100 → ERet=1 in EXEC, in_exc=0.
- MAINDEC_IRQ_EN, irq=4'b0110 during FETCH with in_exc=0 → no IRWrite, EXC next cycle, esr_code=4'b1001, in_exc=1. A second irq while in_exc=1 is ignored.
- Without MAINDEC_IRQ_EN, irq=4'b1111 throughout an R-format sequence → normal 4-cycle execution, esr_code unchanged.
